// File: rtl/data_bus_bridge_pkg.sv
// rtl/data_bus_bridge_pkg.sv - shared types for the core data-bus bridge
// Purpose: FSM state encoding and write-buffer entry layout.
// Entries are sized for a 32-bit address/data bus; the bridge's ADDR_W and
// DATA_W must not exceed BUS_ADDR_W / BUS_DATA_W.
package data_bus_bridge_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    DRAIN,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } bridge_state_e;

  typedef struct packed {
    logic [BUS_ADDR_W-1:0] addr;
    logic [BUS_DATA_W-1:0] data;
  } wbuf_entry_t;

endpackage

// File: rtl/bridge_wbuf.sv
// rtl/bridge_wbuf.sv - posted-write FIFO for the data-bus bridge
// Purpose: synchronous FIFO of {addr, data} entries.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   push_i, push_entry_i enqueue request and entry; accepted when not full or
//                        when a pop frees a slot on the same edge
//   pop_i                dequeue head (ignored when empty)
//   head_o               oldest entry
//   full_o, empty_o      occupancy flags
//   count_o              occupancy
//   lookup_addr_i, hit_o, hit_data_o  youngest-match lookup, only present
//                        when DATA_BUS_BRIDGE_WBUF_FWD_EN is defined
module bridge_wbuf
  import data_bus_bridge_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push_i,
  input  wbuf_entry_t             push_entry_i,
  input  logic                    pop_i,
  output wbuf_entry_t             head_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [$clog2(DEPTH):0]  count_o
`ifdef DATA_BUS_BRIDGE_WBUF_FWD_EN
  ,
  input  logic [BUS_ADDR_W-1:0]   lookup_addr_i,
  output logic                    hit_o,
  output logic [BUS_DATA_W-1:0]   hit_data_o
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbuf_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  // When full, the slot being popped this edge is the one overwritten.
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

`ifdef DATA_BUS_BRIDGE_WBUF_FWD_EN
  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q && mem_q[rd_ptr_q + PW'(i)].addr == lookup_addr_i) begin
        hit_o      = 1'b1;
        hit_data_o = mem_q[rd_ptr_q + PW'(i)].data;
      end
    end
  end
`endif

endmodule

// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - core tri-state data bus to valid/ready memory bridge
// Purpose: posts core writes into a write buffer and drains them to memory in
// order; stalls core reads with core_wait until the buffer has drained and
// the memory response returns, then drives data_bus for one cycle.
// Optional: DATA_BUS_BRIDGE_WBUF_FWD_EN returns read data straight from the
// youngest matching buffered write.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   data_address/data_bus/data_rw/data_cs  core data port (data_bus inout)
//   core_wait                        core must hold its access
//   mem_req_*                        memory request channel (valid/ready)
//   mem_rsp_valid, mem_rsp_rdata     read response
//   wbuf_count                       write-buffer occupancy
module data_bus_bridge
  import data_bus_bridge_pkg::*;
#(
  parameter int WBUF_DEPTH = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ADDR_W-1:0]           data_address,
  inout  wire  [DATA_W-1:0]           data_bus,
  input  logic                        data_rw,
  input  logic                        data_cs,
  output logic                        core_wait,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_we,
  output logic [ADDR_W-1:0]           mem_req_addr,
  output logic [DATA_W-1:0]           mem_req_wdata,
  input  logic                        mem_rsp_valid,
  input  logic [DATA_W-1:0]           mem_rsp_rdata,
  output logic [$clog2(WBUF_DEPTH):0] wbuf_count
);

  bridge_state_e          state_q;
  logic [DATA_W-1:0]      rdata_q;
  logic                   abandon_q;

  wbuf_entry_t            head;
  wbuf_entry_t            push_entry;
  logic                   wb_full;
  logic                   wb_empty;
  logic                   wb_pop;
  logic                   wr_req;
  logic                   rd_req;
  logic                   drain_en;
  logic                   fwd_hit;
  logic [BUS_DATA_W-1:0]  fwd_data;

  // New accesses are only taken in IDLE; elsewhere the core is holding a read.
  assign wr_req     = data_cs && !data_rw && (state_q == IDLE);
  assign rd_req     = data_cs &&  data_rw && (state_q == IDLE);
  assign drain_en   = ((state_q == IDLE) || (state_q == DRAIN)) && !wb_empty;
  assign wb_pop     = drain_en && mem_req_ready;
  assign push_entry = '{addr: BUS_ADDR_W'(data_address), data: BUS_DATA_W'(data_bus)};

  bridge_wbuf #(
    .DEPTH(WBUF_DEPTH)
  ) u_wbuf (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .push_i        (wr_req),
    .push_entry_i  (push_entry),
    .pop_i         (wb_pop),
    .head_o        (head),
    .full_o        (wb_full),
    .empty_o       (wb_empty),
    .count_o       (wbuf_count)
`ifdef DATA_BUS_BRIDGE_WBUF_FWD_EN
    ,
    .lookup_addr_i (BUS_ADDR_W'(data_address)),
    .hit_o         (fwd_hit),
    .hit_data_o    (fwd_data)
`endif
  );

`ifndef DATA_BUS_BRIDGE_WBUF_FWD_EN
  assign fwd_hit  = 1'b0;
  assign fwd_data = '0;
`endif

  always_comb begin
    mem_req_valid = 1'b0;
    mem_req_we    = 1'b0;
    mem_req_addr  = '0;
    mem_req_wdata = '0;
    if (drain_en) begin
      mem_req_valid = 1'b1;
      mem_req_we    = 1'b1;
      mem_req_addr  = ADDR_W'(head.addr);
      mem_req_wdata = DATA_W'(head.data);
    end else if (state_q == RD_REQ) begin
      mem_req_valid = 1'b1;
      mem_req_addr  = data_address;
    end
  end

  // A blocked write is released in the same cycle a pop frees a slot, so the
  // core sees core_wait=0 exactly on the cycle its write is pushed.
  always_comb begin
    core_wait = 1'b0;
    unique case (state_q)
      IDLE:                   core_wait = rd_req || (wr_req && wb_full && !wb_pop);
      DRAIN, RD_REQ, RD_WAIT: core_wait = 1'b1;
      default:                core_wait = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      rdata_q   <= '0;
      abandon_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (rd_req) begin
            abandon_q <= 1'b0;
            if (fwd_hit) begin
              rdata_q <= DATA_W'(fwd_data);
              state_q <= RD_DONE;
            end else if (wb_empty) begin
              state_q <= RD_REQ;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!data_cs) abandon_q <= 1'b1;
          if (wb_empty) state_q <= RD_REQ;
        end
        RD_REQ: begin
          if (!data_cs) abandon_q <= 1'b1;
          if (mem_req_ready) begin
            if (mem_rsp_valid) begin
              rdata_q <= mem_rsp_rdata;
              state_q <= RD_DONE;
            end else begin
              state_q <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (!data_cs) abandon_q <= 1'b1;
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_rdata;
            state_q <= RD_DONE;
          end
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // A read the core walked away from is completed but never returned.
  assign data_bus = (state_q == RD_DONE && !abandon_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - scoreboard bench for data_bus_bridge
module tb_data_bus_bridge;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] data_address;
  wire  [DW-1:0] data_bus;
  logic          data_rw;
  logic          data_cs;
  logic          core_wait;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic          mem_req_we;
  logic [AW-1:0] mem_req_addr;
  logic [DW-1:0] mem_req_wdata;
  logic          mem_rsp_valid;
  logic [DW-1:0] mem_rsp_rdata;
  logic [2:0]    wbuf_count;

  logic          tb_drv;
  logic [DW-1:0] tb_wdata;
  assign data_bus = tb_drv ? tb_wdata : 'z;

  always #5 clk = ~clk;

  data_bus_bridge #(.WBUF_DEPTH(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_address  (data_address),
    .data_bus      (data_bus),
    .data_rw       (data_rw),
    .data_cs       (data_cs),
    .core_wait     (core_wait),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_we    (mem_req_we),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .wbuf_count    (wbuf_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: the core's view of memory (every accepted write, in issue order)
  // and the external memory contents as seen by the responder.
  logic [DW-1:0] ref_mem   [logic [AW-1:0]];
  logic [DW-1:0] mem_model [logic [AW-1:0]];

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_wq[$];
  logic [DW-1:0] exp_rq[$];
  logic [DW-1:0] rd_exp;
  int            force_ready = 0;   // -1 random, 0 low, 1 high
  int            rsp_lat = 1;       // -1 random 0..3
  int            mem_reads = 0;
  bit            rd_active = 1'b0;

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic summary_and_finish();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic abort(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: cycle budget expired", name);
    summary_and_finish();
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mem_model[a] = d;
    ref_mem[a]   = d;
  endtask

  // Memory responder and write/read-request monitor.
  initial begin : responder
    bit            rd_pend;
    int            rd_cnt;
    int            lat;
    logic [DW-1:0] rd_val;
    wr_t           w;
    rd_pend = 1'b0;
    rd_cnt  = 0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rsp_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      mem_rsp_valid = 1'b0;
      mem_req_ready = (force_ready < 0) ? ($urandom_range(0, 99) < 70) : (force_ready != 0);
      if (rd_pend) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = rd_val;
          rd_pend = 1'b0;
        end
      end
      if (rst_n && mem_req_valid && mem_req_ready) begin
        if (mem_req_we) begin
          if (exp_wq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, none expected", mem_req_addr, mem_req_wdata);
          end else begin
            w = exp_wq.pop_front();
            check("wr_addr", mem_req_addr, w.a);
            check("wr_data", mem_req_wdata, w.d);
          end
          mem_model[mem_req_addr] = mem_req_wdata;
        end else begin
          check("rd_after_writes", exp_wq.size(), 0);
          mem_reads++;
          rd_val = mem_model.exists(mem_req_addr) ? mem_model[mem_req_addr] : init_val(mem_req_addr);
          lat = (rsp_lat < 0) ? $urandom_range(0, 3) : rsp_lat;
          if (lat == 0) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rd_val;
          end else begin
            rd_pend = 1'b1;
            rd_cnt  = lat;
          end
        end
      end
    end
  end

  // Read-data monitor: the DUT presents read data when the held read sees core_wait=0.
  always @(negedge clk) begin
    if (rst_n && rd_active && !core_wait) begin
      if (exp_rq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_read_data: got 0x%0h, none expected", data_bus);
      end else begin
        rd_exp = exp_rq.pop_front();
        check("rd_data", data_bus, rd_exp);
      end
    end
  end

  task automatic core_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int waits);
    waits = 0;
    data_cs = 1'b1; data_rw = 1'b0; data_address = a; tb_wdata = d; tb_drv = 1'b1;
    forever begin
      @(negedge clk);
      if (!core_wait) break;
      waits++;
      if (waits > 500) abort("write_timeout");
      @(posedge clk);
      #1;
    end
    ref_mem[a] = d;
    exp_wq.push_back('{a: a, d: d});
    sync();
    data_cs = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic core_read(input logic [AW-1:0] a, output int waits);
    waits = 0;
    exp_rq.push_back(ref_mem.exists(a) ? ref_mem[a] : init_val(a));
    data_cs = 1'b1; data_rw = 1'b1; data_address = a; rd_active = 1'b1;
    forever begin
      @(negedge clk);
      if (!core_wait) break;
      waits++;
      if (waits > 500) abort("read_timeout");
      @(posedge clk);
      #1;
    end
    sync();
    data_cs = 1'b0; rd_active = 1'b0;
  endtask

  task automatic wait_empty();
    int guard = 0;
    while (wbuf_count != 0 || exp_wq.size() != 0) begin
      sync();
      guard++;
      if (guard > 1000) abort("drain_timeout");
    end
  endtask

  initial begin : main
    int            w;
    int            reads_before;
    logic [AW-1:0] ra;
    data_cs = 1'b0; data_rw = 1'b0; data_address = '0; tb_drv = 1'b0; tb_wdata = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_core_wait", core_wait, 0);
    check("rst_req_valid", mem_req_valid, 0);
    check("rst_req_we", mem_req_we, 0);
    check("rst_req_addr", mem_req_addr, 0);
    check("rst_req_wdata", mem_req_wdata, 0);
    check("rst_wbuf_count", wbuf_count, 0);
    rst_n = 1'b1;
    sync();

    // Posted writes fill the buffer with zero wait.
    force_ready = 0;
    for (int i = 0; i < 4; i++) begin
      core_write(32'h100 + 4 * i, 32'hA0 + i, w);
      check("post_wait", w, 0);
    end
    @(negedge clk);
    check("post_count", wbuf_count, 4);
    check("head_valid", mem_req_valid, 1);
    check("head_we", mem_req_we, 1);
    check("head_addr", mem_req_addr, 32'h100);
    check("head_data", mem_req_wdata, 32'hA0);
    sync();
    // Fifth write waits until a single ready cycle frees a slot.
    fork
      core_write(32'h110, 32'hA4, w);
      begin
        repeat (3) @(posedge clk);
        force_ready = 1;
        @(posedge clk);
        force_ready = 0;
      end
    join
    check("full_wait", w, 3);
    @(negedge clk);
    check("full_count", wbuf_count, 4);
    sync();
    force_ready = 1;
    wait_empty();

    // Read with empty buffer: response one cycle after the request.
    preload(32'h200, 32'hDEADBEEF);
    rsp_lat = 1;
    core_read(32'h200, w);
    check("rd_wait_lat1", w, 3);
    // Minimum latency: response in the same cycle as ready.
    rsp_lat = 0;
    core_read(32'h204, w);
    check("rd_wait_lat0", w, 2);

    // Read after buffered writes must drain first.
    force_ready = 0;
    rsp_lat = 1;
    core_write(32'h304, 32'h33, w);
    core_write(32'h308, 32'h34, w);
    force_ready = 1;
    core_read(32'h300, w);
    check("rd_drained", exp_wq.size(), 0);

    // Simultaneous push and pop on a full buffer.
    force_ready = 0;
    for (int i = 0; i < 4; i++) core_write(32'h700 + 4 * i, 32'hC0 + i, w);
    force_ready = 1;
    core_write(32'h710, 32'hC4, w);
    check("pushpop_wait", w, 0);
    force_ready = 0;
    @(negedge clk);
    check("pushpop_count", wbuf_count, 4);
    sync();
    force_ready = 1;
    wait_empty();

    // Reset while waiting for a read response; the late response is ignored.
    rsp_lat = 3;
    data_cs = 1'b1; data_rw = 1'b1; data_address = 32'h500;
    sync();
    sync();
    rst_n = 1'b0; data_cs = 1'b0;
    #1;
    check("midrst_core_wait", core_wait, 0);
    check("midrst_req_valid", mem_req_valid, 0);
    check("midrst_req_addr", mem_req_addr, 0);
    check("midrst_count", wbuf_count, 0);
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("postrst_core_wait", core_wait, 0);
      check("postrst_req_valid", mem_req_valid, 0);
    end
    sync();
    rsp_lat = 1;
    core_read(32'h504, w);
    check("postrst_rd_wait", w, 3);

    // Read of an address with buffered writes.
    force_ready = 0;
    core_write(32'h400, 32'h11, w);
    core_write(32'h400, 32'h22, w);
`ifdef DATA_BUS_BRIDGE_WBUF_FWD_EN
    reads_before = mem_reads;
    core_read(32'h400, w);
    check("fwd_wait", w, 1);
    check("fwd_no_mem_read", mem_reads, reads_before);
    @(negedge clk);
    check("fwd_count", wbuf_count, 2);
    sync();
    force_ready = 1;
    wait_empty();
`else
    force_ready = 1;
    reads_before = mem_reads;
    core_read(32'h400, w);
    check("nofwd_mem_read", mem_reads, reads_before + 1);
    check("nofwd_wait_ge3", (w >= 3), 1);
`endif

    // Randomized mix of writes and reads over a small address window.
    force_ready = -1;
    rsp_lat = -1;
    for (int n = 0; n < 300; n++) begin
      ra = 32'h600 + 4 * $urandom_range(0, 7);
      if ($urandom_range(0, 99) < 60) core_write(ra, $urandom, w);
      else core_read(ra, w);
      if ($urandom_range(0, 3) == 0) sync();
    end

    force_ready = 1;
    wait_empty();
    repeat (5) sync();
    check("end_wq_empty", exp_wq.size(), 0);
    check("end_rq_empty", exp_rq.size(), 0);
    summary_and_finish();
  end

endmodule

// File: doc/data_bus_bridge.md
Name: data_bus_bridge

Overview:
- Sits directly downstream of the core's data port (data_address / data_bus / data_rw / data_cs).
- Converts the core's tri-state, chip-select data bus into a valid/ready request plus response-valid memory interface.
- Writes are posted into a small write buffer.
- Reads stall the core through core_wait until external read data returns, then drive data_bus.

Parameters:
- WBUF_DEPTH, 4, write-buffer entries; power of two, >=2.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- data_address  in  ADDR_W  core data address
- data_bus  inout  DATA_W  core data bus; driven by bridge only during read return
- data_rw  in  1  1 = read, 0 = write; valid while data_cs=1
- data_cs  in  1  core access strobe, one access per cycle
- core_wait  out  1  core must hold data_cs/data_rw/data_address (and write data) stable
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_we  out  1  1 = write request
- mem_req_addr  out  ADDR_W  request address
- mem_req_wdata  out  DATA_W  write data
- mem_rsp_valid  in  1  read response valid, one pulse per read request
- mem_rsp_rdata  in  DATA_W  read response data
- wbuf_count  out  $clog2(WBUF_DEPTH)+1  current write-buffer occupancy

Behaviour:
- Reset values (asynchronous, rst_n=0):
  - FSM = IDLE; write buffer empty; wbuf_count=0.
  - core_wait=0; mem_req_valid=0; mem_req_we=0; mem_req_addr=0; mem_req_wdata=0.
  - data_bus released (high-Z).
  - Reset mid-transaction discards buffered writes and any outstanding read; a late mem_rsp_valid after reset is ignored.
- Write path:
  - A write (data_cs=1, data_rw=0) with buffer not full pushes {address, data_bus} at the clock edge, with core_wait=0 (zero-wait posted write).
  - Buffer full: core_wait=1 combinationally; push occurs on the first edge where a slot is free, including the same edge a pop frees one.
- Drain:
  - Whenever FSM is IDLE or DRAIN and the buffer is non-empty, the head is presented: mem_req_valid=1, we=1.
  - Pop on mem_req_valid && mem_req_ready.
  - Push and pop in the same cycle leave the count unchanged.
  - Requests are issued strictly in FIFO order.
- Read path FSM, IDLE -> DRAIN -> RD_REQ -> RD_WAIT -> RD_DONE -> IDLE:
  - IDLE: a read seen (data_cs=1, data_rw=1) -> core_wait=1. Go to DRAIN if buffer non-empty, else RD_REQ.
  - DRAIN: stay until buffer empty, then go to RD_REQ. Reads are never reordered ahead of buffered writes.
  - RD_REQ: mem_req_valid=1, we=0, addr=data_address. Go to RD_WAIT on ready.
  - RD_WAIT: capture mem_rsp_rdata on mem_rsp_valid, then go to RD_DONE. A response arriving in the same cycle as ready is legal: go directly to RD_DONE.
  - RD_DONE: core_wait=0, data_bus driven with captured data for exactly one cycle, then return to IDLE.
- Latency: minimum read latency with buffer empty, ready=1 and response in the same cycle = 2 cycles of core_wait, then 1 data cycle.
- core_wait is 1 in DRAIN, RD_REQ and RD_WAIT.
- Writes issued by the core while core_wait=1 are the held access and are not double-pushed.
- data_cs deasserted during core_wait is a protocol violation; the bridge completes the read and discards the data.
- mem_rsp_valid outside RD_WAIT/RD_REQ is ignored.

Optional Feature:
- Macro: DATA_BUS_BRIDGE_WBUF_FWD_EN.
- Defined:
  - In IDLE, a read whose address matches any buffered entry returns the youngest matching data in RD_DONE after 1 core_wait cycle.
  - No drain and no memory read are performed.
  - A non-matching read still drains first.
- Undefined: all reads drain the buffer and go to memory.

Decomposition:
- Package data_bus_bridge_pkg: FSM state enum (IDLE, DRAIN, RD_REQ, RD_WAIT, RD_DONE) and the write-buffer entry struct {addr, data}.
- One sub-module, bridge_wbuf: a synchronous FIFO with push/pop, full/empty, count. With forwarding enabled it also provides a combinational youngest-match lookup port.

Test Plan:
1. Posted writes: 4 writes (0x100..0x10C, data 0xA0..0xA3) with mem_req_ready=0 -> core_wait stays 0, wbuf_count=4. A 5th write raises core_wait until ready=1 for one cycle; memory then sees the writes in order 0x100 first.
2. Read with empty buffer: read 0x200, ready=1, response 0xDEADBEEF one cycle later -> core_wait high 3 cycles, then data_bus=0xDEADBEEF for 1 cycle, then high-Z.
3. Read after writes: 2 buffered writes, then read 0x300 -> both writes complete before the read request (mem_req_we=0) appears.
4. Simultaneous push/pop: buffer full, ready=1, core writes the same cycle -> count stays 4, no write lost, order preserved.
5. Reset mid-read: assert rst_n=0 in RD_WAIT -> all outputs at reset values immediately; a later mem_rsp_valid pulse produces no data_bus drive.
6. Forwarding (DATA_BUS_BRIDGE_WBUF_FWD_EN): writes 0x400=0x11 then 0x400=0x22, ready=0, read 0x400 -> 0x22 returned after 1 wait cycle, no read request issued. Without the macro -> writes drain first, then memory read.
